// File: rtl/output_scan_reader_pkg.sv
// Shared types for the output-memory scan reader.
// Scan-mode encoding is common with the output memory.
package output_scan_reader_pkg;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 8;

  typedef enum logic [1:0] {
    SCAN_IN  = 2'd0,
    LOAD     = 2'd1,
    WRITE    = 2'd2,
    SCAN_OUT = 2'd3
  } scan_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/wide_piso.sv
// Wide parallel-in / serial-out register.
// Emits the low beat first; counts beats to flag the last.
module wide_piso #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      advance,
  input  logic [BEAT_W*BEATS-1:0]   data,
  output logic [BEAT_W-1:0]         beat,
  output logic                      last_beat
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W*BEATS-1:0] sr;
  logic [CW-1:0]           cnt;

  // Capture a word on load, shift one beat down per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= '0;
    end else if (advance) begin
      sr  <= sr >> BEAT_W;
      cnt <= cnt + CW'(1);
    end
  end

  assign beat      = sr[BEAT_W-1:0];
  assign last_beat = (cnt == CW'(BEATS - 1));

endmodule

// File: rtl/output_scan_reader.sv
// Drains words from the output memory via its scan port
// and serializes each word onto a valid/ready beat stream.
module output_scan_reader #(
  parameter int BEAT_W = output_scan_reader_pkg::BEAT_W,
  parameter int BEATS  = output_scan_reader_pkg::BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              base_addr,
  input  logic [7:0]              word_count,
  output logic [1:0]              scan_mode,
  output logic [7:0]              scan_addr,
  input  logic [BEAT_W*BEATS-1:0] mem_scan_out,
  output logic [BEAT_W-1:0]       stream_data,
  output logic                    stream_valid,
  input  logic                    stream_ready,
  output logic                    stream_last,
  output logic                    busy,
  output logic                    done
);

  import output_scan_reader_pkg::*;

  state_t     state;
  state_t     state_nx;
  logic [7:0] addr;
  logic [7:0] words_left;
  logic       xfer;
  logic       piso_last;
  logic       final_word;
  logic       word_end;

  assign xfer       = stream_valid && stream_ready;
  assign final_word = (words_left == 8'd1);
  assign word_end   = xfer && piso_last;

  wide_piso #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (state == WAIT),
    .advance   (xfer),
    .data      (mem_scan_out),
    .beat      (stream_data),
    .last_beat (piso_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (word_count == 8'd0) ? DONE : REQ;
      end
      REQ:  state_nx = WAIT;
      WAIT: state_nx = SEND;
      SEND: begin
        if (word_end)
          state_nx = final_word ? DONE : REQ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word address and remaining-word count for the drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= 8'd0;
      words_left <= 8'd0;
    end else if (state == IDLE && start) begin
      addr       <= base_addr;
      words_left <= word_count;
    end else if (word_end) begin
      addr       <= addr + 8'd1;
      words_left <= words_left - 8'd1;
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    scan_mode    = LOAD;
    scan_addr    = 8'd0;
    busy         = 1'b1;
    done         = 1'b0;
    stream_valid = 1'b0;
    unique case (state)
      IDLE: busy = 1'b0;
      REQ, WAIT: begin
        scan_mode = SCAN_OUT;
        scan_addr = addr;
      end
      SEND: begin
        scan_mode    = SCAN_OUT;
        scan_addr    = addr;
        stream_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign stream_last = stream_valid && piso_last && final_word;

endmodule

// File: tb/tb_output_scan_reader.sv
// Self-checking bench for output_scan_reader.
// Memory contents are random; beats are predicted from them.
module tb_output_scan_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   base_addr;
  logic [7:0]   word_count;
  logic [1:0]   scan_mode;
  logic [7:0]   scan_addr;
  logic [511:0] mem_scan_out;
  logic [63:0]  stream_data;
  logic         stream_valid;
  logic         stream_ready;
  logic         stream_last;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [511:0] mem [256];

  logic [63:0] got_q[$];
  logic        last_q[$];
  logic [7:0]  adr_q[$];
  int done_cnt, mode3_cnt, valid_cnt, stall_err;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  output_scan_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .scan_mode    (scan_mode),
    .scan_addr    (scan_addr),
    .mem_scan_out (mem_scan_out),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_last  (stream_last),
    .busy         (busy),
    .done         (done)
  );

  // one-cycle-latency memory read port
  always @(posedge clk) mem_scan_out <= mem[scan_addr];

  // observe transfers, stalls and pulses mid-cycle
  always @(negedge clk) begin
    if (stream_valid && stream_ready) begin
      got_q.push_back(stream_data);
      last_q.push_back(stream_last);
      adr_q.push_back(scan_addr);
    end
    if (prev_stall && (!stream_valid || stream_data !== prev_data
                       || stream_last !== prev_last))
      stall_err++;
    prev_stall = stream_valid && !stream_ready && !reset;
    prev_data  = stream_data;
    prev_last  = stream_last;
    if (done) done_cnt++;
    if (scan_mode == 2'd3) mode3_cnt++;
    if (stream_valid) valid_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    adr_q.delete();
    done_cnt = 0;
    mode3_cnt = 0;
    valid_cnt = 0;
    stall_err = 0;
    prev_stall = 1'b0;
  endtask

  function automatic logic rdy(input int pat, input int c);
    case (pat)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Reference: beat i of the drain is 64-bit slice (i%8) of word
  // (base + i/8) mod 256; only the very last beat carries last.
  function automatic int beat_errs(input logic [7:0] base,
                                   input logic [7:0] cnt);
    int e = 0;
    int n = 8 * int'(cnt);
    logic [7:0] a;
    logic [511:0] w;
    if (got_q.size() != n) return -1;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i / 8);
      w = mem[a];
      if (got_q[i] !== w[(i % 8) * 64 +: 64]) e++;
      if (last_q[i] !== (i == n - 1)) e++;
      if (adr_q[i] !== a) e++;
    end
    return e;
  endfunction

  task automatic drain(input logic [7:0] base, input logic [7:0] cnt,
                       input int pat, input bit spam,
                       output bit timed_out);
    clear_mon();
    base_addr = base;
    word_count = cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      stream_ready = rdy(pat, c);
      if (spam) begin
        start = (c % 4) == 1;
        base_addr = 8'($urandom);
        word_count = 8'($urandom);
      end
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stream_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({busy, done, stream_valid, stream_last, stream_data, scan_addr,
         scan_mode} !== {4'b0, 64'h0, 8'h0, 2'd1}) begin
      fails++;
      $display("FAIL reset_outputs: got b%0b d%0b v%0b l%0b data=%h addr=%h mode=%0d, want all 0 and mode=1",
               busy, done, stream_valid, stream_last, stream_data,
               scan_addr, scan_mode);
    end
  endtask

  task automatic test_single_word();
    logic [511:0] w;
    int e = 0;
    logic [63:0] eb;
    for (int k = 0; k < 8; k++)
      w[k * 64 +: 64] = {32'($urandom), 24'hC0FFEE, 8'(k)};
    mem[8'h10] = w;
    clear_mon();
    stream_ready = 1'b1;
    base_addr = 8'h10;
    word_count = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      eb = (t >= 3 && t <= 10) ? w[(t - 3) * 64 +: 64] : 64'h0;
      tests++;
      if (busy !== (t <= 11) || done !== (t == 11)
          || stream_valid !== (t >= 3 && t <= 10)
          || stream_last !== (t == 10)
          || scan_mode !== ((t <= 10) ? 2'd3 : 2'd1)
          || scan_addr !== ((t <= 10) ? 8'h10 : 8'h00)
          || (stream_valid && stream_data !== eb)) begin
        fails++;
        e++;
        $display("FAIL single_word T+%0d: b%0b d%0b v%0b l%0b mode=%0d addr=%h data=%h want data=%h",
                 t, busy, done, stream_valid, stream_last, scan_mode,
                 scan_addr, stream_data, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit to;
    int e;
    logic [7:0] b, n;
    int pat;
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      n = 8'($urandom_range(1, 5));
      pat = $urandom_range(0, 2);
      drain(b, n, pat, 1'b0, to);
      e = beat_errs(b, n);
      tests++;
      if (to || e != 0 || done_cnt != 1 || stall_err != 0) begin
        fails++;
        $display("FAIL random_drain base=%h cnt=%0d pat=%0d: timeout=%0b errs=%0d done=%0d stall=%0d, want 0,0,1,0",
                 b, n, pat, to, e, done_cnt, stall_err);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int e;
    drain(8'h40, 8'd3, 1, 1'b0, to);
    e = beat_errs(8'h40, 8'd3);
    tests++;
    if (to || got_q.size() != 24 || e != 0) begin
      fails++;
      $display("FAIL backpressure_beats: timeout=%0b beats=%0d errs=%0d, want 24 beats 0 errs",
               to, got_q.size(), e);
    end
    tests++;
    if (stall_err != 0) begin
      fails++;
      $display("FAIL backpressure_stable: stall violations=%0d want 0",
               stall_err);
    end
  endtask

  task automatic test_wrap();
    bit to;
    int e;
    drain(8'hFE, 8'd3, 0, 1'b0, to);
    e = beat_errs(8'hFE, 8'd3);
    tests++;
    if (to || got_q.size() != 24 || e != 0) begin
      fails++;
      $display("FAIL wrap_beats: timeout=%0b beats=%0d errs=%0d, want 24 beats 0 errs",
               to, got_q.size(), e);
    end else begin
      tests++;
      if ({adr_q[0], adr_q[8], adr_q[16]} !== 24'hFEFF00) begin
        fails++;
        $display("FAIL wrap_addr: got %h %h %h want fe ff 00",
                 adr_q[0], adr_q[8], adr_q[16]);
      end
    end
  endtask

  task automatic test_zero();
    clear_mon();
    base_addr = 8'h33;
    word_count = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || scan_mode !== 2'd1) begin
      fails++;
      $display("FAIL zero_t1: done=%0b busy=%0b mode=%0d want 1 1 1",
               done, busy, scan_mode);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_t2: done=%0b busy=%0b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (mode3_cnt != 0 || valid_cnt != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL zero_quiet: mode3=%0d valid=%0d done=%0d want 0 0 1",
               mode3_cnt, valid_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int e;
    logic [7:0] b;
    logic [511:0] w;
    b = 8'($urandom);
    w = mem[b + 8'd1];
    clear_mon();
    stream_ready = 1'b1;
    base_addr = b;
    word_count = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    tests++;
    if (stream_valid !== 1'b1 || stream_data !== w[3 * 64 +: 64]) begin
      fails++;
      $display("FAIL mid_beat3: valid=%0b data=%h want 1 %h",
               stream_valid, stream_data, w[3 * 64 +: 64]);
    end
    stream_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stream_ready = 1'b1;
    tests++;
    if ({busy, done, stream_valid, stream_last, stream_data, scan_addr,
         scan_mode} !== {4'b0, 64'h0, 8'h0, 2'd1}) begin
      fails++;
      $display("FAIL mid_reset_outputs: b%0b d%0b v%0b l%0b data=%h addr=%h mode=%0d, want 0s mode=1",
               busy, done, stream_valid, stream_last, stream_data,
               scan_addr, scan_mode);
    end
    repeat (30) @(posedge clk);
    #1;
    tests++;
    if (done_cnt != 0 || got_q.size() != 11 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_abandon: done=%0d beats=%0d busy=%0b want 0 11 0",
               done_cnt, got_q.size(), busy);
    end
    drain(8'h80, 8'd2, 2, 1'b0, to);
    e = beat_errs(8'h80, 8'd2);
    tests++;
    if (to || e != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL mid_restart: timeout=%0b errs=%0d done=%0d want 0 0 1",
               to, e, done_cnt);
    end
  endtask

  task automatic test_busy_start();
    bit to;
    int e;
    drain(8'h20, 8'd2, 0, 1'b1, to);
    e = beat_errs(8'h20, 8'd2);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (to || e != 0 || done_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: timeout=%0b errs=%0d done=%0d busy=%0b want 0 0 1 0",
               to, e, done_cnt, busy);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = 8'h0;
    word_count = 8'h0;
    stream_ready = 1'b1;
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 16; k++)
        mem[a][k * 32 +: 32] = $urandom;
    clear_mon();
    @(posedge clk); #1;
    test_reset();
    test_single_word();
    test_random();
    test_backpressure();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_scan_reader.md
OUTPUT_SCAN_READER -- requirements
Module: output_scan_reader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports `clk` and `reset`.
REQ-002 Parameters, as name, default, meaning:
- `BEAT_W`, 64, stream beat width.
- `BEATS`, 8, beats per 512-bit word (`BEAT_W`*`BEATS` = 512).
REQ-003 Ports, as name, direction, width, meaning:
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous active-high reset.
- `start`, in, 1, begin drain; sampled only in IDLE.
- `base_addr`, in, 8, first output-memory word address; sampled with `start`.
- `word_count`, in, 8, number of 512-bit words to drain; sampled with `start`.
- `scan_mode`, out, 2, drives output-memory scan_mode.
- `scan_addr`, out, 8, drives output-memory scan_addr.
- `mem_scan_out`, in, 512, output-memory scan_out.
- `stream_data`, out, `BEAT_W`, serialized beat.
- `stream_valid`, out, 1, beat valid.
- `stream_ready`, in, 1, sink accepts beat.
- `stream_last`, out, 1, final beat of final word.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, one-cycle completion pulse.

Function
REQ-004 `scan_mode` encoding SHALL be SCAN_IN=0, LOAD=1, WRITE=2, SCAN_OUT=3.
- `scan_mode` is LOAD (1) in IDLE and DONE.
- `scan_mode` is SCAN_OUT (3) in REQ, WAIT and SEND.
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, SEND and DONE.
- IDLE→REQ on `start` when `word_count` != 0.
- IDLE→DONE on `start` when `word_count` == 0.
- REQ→WAIT unconditionally.
- WAIT→SEND unconditionally, capturing `mem_scan_out` into a 512-bit shift register on that edge.
- SEND→REQ after the last beat of a word is accepted and words remain.
- SEND→DONE after the last beat of the last word is accepted.
- DONE→IDLE unconditionally.
REQ-006 `scan_addr` SHALL equal the current word address in REQ, WAIT and SEND.
- The first word address is `base_addr`.
- The address increments by 1 per word, modulo 256 (255 wraps to 0).
- `scan_addr` is 0 in IDLE.
REQ-007 Memory read latency SHALL be one cycle: the data for the address presented in REQ is valid in WAIT.
REQ-008 Beat order SHALL be least-significant first: beat k = bits [64k+63:64k], k = 0..7.
REQ-009 `stream_valid` SHALL be high only in SEND.
- A beat transfers on a cycle with `stream_valid` && `stream_ready`.
- `stream_data` and `stream_last` SHALL hold stable while `stream_valid` && !`stream_ready`.
REQ-010 `stream_last` SHALL be high only on beat 7 of word `word_count`-1.
REQ-011 Latency: with `start` sampled at edge T and `stream_ready` held at 1:
- REQ occupies cycle T+1 and WAIT occupies T+2.
- Beat 0 is valid in T+3.
- Each word takes 10 cycles.
- `done` is high in the cycle after the final beat transfers.
REQ-012 `start` SHALL be ignored while `busy` is high; `base_addr` and `word_count` are latched only at accepted `start`.
REQ-013 `done` SHALL be high for exactly one cycle per accepted `start`, including when `word_count` == 0.

Reset
REQ-014 On `reset`, outputs SHALL take these values on the next edge, regardless of state:
- state IDLE.
- `busy`, `done`, `stream_valid` and `stream_last` 0.
- `stream_data` 0.
- `scan_addr` 0.
- `scan_mode` LOAD.
REQ-015 Reset mid-drain SHALL abandon the drain without emitting further beats or a `done` pulse.

Structure
REQ-016 A shared package SHALL hold:
- the `scan_mode_t` enum (SCAN_IN, LOAD, WRITE, SCAN_OUT), shared with the output memory.
- `BEAT_W` and `BEATS` constants.
- the FSM state typedef.
REQ-017 The 512-to-64 parallel-in/serial-out register with beat counter SHALL be a sub-module `wide_piso`, with ports load, advance, data, last_beat.

Verification
REQ-018 Single word: `base_addr`=0x10, `word_count`=1, word = {8 beats 0x..07..0x..00}, `stream_ready`=1.
- Required: beats 0..7 appear in order on cycles T+3..T+10.
- Required: `stream_last` is high only at T+10; `done` is high at T+11; `scan_addr`=0x10 during T+1..T+10.
REQ-019 Backpressure: `stream_ready` toggles 1,0,0,1,...
- Required: no beat is lost or duplicated.
- Required: `stream_data` is stable during stalls.
- Required: total beats = 8·`word_count`.
REQ-020 Address wrap: `base_addr`=0xFE, `word_count`=3 → `scan_addr` sequence is 0xFE, 0xFF, 0x00 and 24 beats are emitted.
REQ-021 Zero count: `start` with `word_count`=0 → no `stream_valid`, `scan_mode` never 3, `done` high at T+1.
REQ-022 Reset mid-drain: assert `reset` during beat 3 of word 1 of 4.
- Required: all outputs reach their reset values next cycle and no `done` pulse occurs.
- Required: a new `start` then drains correctly.
REQ-023 `start` pulsed while busy SHALL be ignored: only the first drain's beats appear, and exactly one `done` pulse occurs.
